// File: rtl/boot_pkg.sv
// Shared types and constants for the flash boot loader.
package boot_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CMD_SEND,
    CMD_WAIT,
    ADDR_SEND,
    ADDR_WAIT,
    DUMMY_SEND,
    DUMMY_WAIT,
    DATA_SEND,
    DATA_WAIT,
    SRAM_WRITE,
    CS_END,
    DONE,
    ERROR
  } boot_state_t;

  localparam logic [7:0] FLASH_CMD_READ      = 8'h03;
  localparam logic [7:0] FLASH_CMD_FAST_READ = 8'h0B;

endpackage

// File: rtl/flash_boot_loader_if.sv
// Boot request, SPI engine and SRAM write signals of the flash boot loader.
interface flash_boot_loader_if #(
  parameter int unsigned WORD_BYTES = 4
);

  logic                      boot_req_i;
  logic                      spi_start_o;
  logic [7:0]                spi_out_o;
  logic [7:0]                spi_in_i;
  logic                      spi_done_i;
  logic                      spi_busy_i;
  logic                      flash_csb_o;
  logic                      sram_wr_en_o;
  logic                      sram_ready_i;
  logic [31:0]               sram_addr_o;
  logic [8*WORD_BYTES-1:0]   sram_data_o;
  logic                      cores_en_o;
  logic                      boot_done_o;
  logic                      boot_err_o;
  logic [31:0]               boot_sum_o;

  // Loader side
  modport master (
    input  boot_req_i, spi_in_i, spi_done_i, spi_busy_i, sram_ready_i,
    output spi_start_o, spi_out_o, flash_csb_o, sram_wr_en_o, sram_addr_o,
           sram_data_o, cores_en_o, boot_done_o, boot_err_o, boot_sum_o
  );

  // SPI engine / SRAM / system side
  modport slave (
    output boot_req_i, spi_in_i, spi_done_i, spi_busy_i, sram_ready_i,
    input  spi_start_o, spi_out_o, flash_csb_o, sram_wr_en_o, sram_addr_o,
           sram_data_o, cores_en_o, boot_done_o, boot_err_o, boot_sum_o
  );

endinterface

// File: rtl/boot_word_packer.sv
// Assembles received flash bytes into one SRAM word, lane order set by BIG_ENDIAN.
module boot_word_packer #(
  parameter int unsigned WORD_BYTES = 4,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    load,
  input  logic [7:0]              byte_in,
  output logic [8*WORD_BYTES-1:0] word,
  output logic                    full
);

  localparam int unsigned CNT_W = $clog2(WORD_BYTES + 1);

  logic [CNT_W-1:0] byte_in_word;
  int unsigned      lane;

  always_comb begin
    lane = BIG_ENDIAN ? (WORD_BYTES - 1 - 32'(byte_in_word)) : 32'(byte_in_word);
    // Asserted when the byte being loaded now completes the word
    full = (32'(byte_in_word) == WORD_BYTES - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word         <= '0;
      byte_in_word <= '0;
    end else if (clear) begin
      word         <= '0;
      byte_in_word <= '0;
    end else if (load) begin
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
        if (i == lane) word[i*8 +: 8] <= byte_in;
      end
      byte_in_word <= byte_in_word + CNT_W'(1);
    end
  end

endmodule

// File: rtl/flash_boot_loader.sv
// Copies a BOOT_SIZE-byte image from SPI NOR flash into SRAM, then enables the cores.
module flash_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned BOOT_SIZE       = 32,
  parameter logic [23:0] FLASH_BASE_ADDR = 24'h000000,
  parameter logic [31:0] SRAM_BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned WORD_BYTES      = 4,
  parameter bit          FAST_READ       = 1'b0,
  parameter bit          BIG_ENDIAN      = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  flash_boot_loader_if.master bus
);

  localparam int unsigned CW = $clog2(BOOT_SIZE + 1);
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(BOOT_SIZE - 1);
  localparam logic [CW-1:0] ALL_BYTES = CW'(BOOT_SIZE);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]   ADDR_STEP = 32'(WORD_BYTES);
  localparam logic [7:0]    CMD_BYTE  = FAST_READ ? FLASH_CMD_FAST_READ : FLASH_CMD_READ;

  boot_state_t             state;
  logic [CW-1:0]           byte_cntr;
  logic [WW-1:0]           wdog;
  logic [1:0]              addr_idx;
  logic [31:0]             addr_reg;
  logic [7:0]              addr_byte;
  logic                    is_wait;
  logic                    wd_expired;
  logic                    spi_go;
  logic                    pack_load;
  logic                    pack_clear;
  logic                    pack_full;
  logic                    accept;
  logic                    restart;
  logic [8*WORD_BYTES-1:0] word;

  always_comb begin
    case (addr_idx)
      2'd0:    addr_byte = FLASH_BASE_ADDR[23:16];
      2'd1:    addr_byte = FLASH_BASE_ADDR[15:8];
      default: addr_byte = FLASH_BASE_ADDR[7:0];
    endcase
    is_wait    = (state == CMD_WAIT) || (state == ADDR_WAIT) ||
                 (state == DUMMY_WAIT) || (state == DATA_WAIT);
    wd_expired = (wdog == WD_LAST);
    spi_go     = !bus.spi_busy_i;
    pack_load  = (state == DATA_WAIT) && bus.spi_done_i;
    accept     = (state == SRAM_WRITE) && bus.sram_ready_i;
    restart    = ((state == DONE) || (state == ERROR)) && bus.boot_req_i;
    pack_clear = accept || restart;
  end

  boot_word_packer #(
    .WORD_BYTES (WORD_BYTES),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_packer (
    .clk     (clk_i),
    .rst_n   (reset_ni),
    .clear   (pack_clear),
    .load    (pack_load),
    .byte_in (bus.spi_in_i),
    .word    (word),
    .full    (pack_full)
  );

  assign bus.sram_data_o = word;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state            <= IDLE;
      byte_cntr        <= '0;
      wdog             <= '0;
      addr_idx         <= '0;
      addr_reg         <= SRAM_BASE_ADDR;
      bus.flash_csb_o  <= 1'b1;
      bus.spi_start_o  <= 1'b0;
      bus.spi_out_o    <= '0;
      bus.sram_wr_en_o <= 1'b0;
      bus.sram_addr_o  <= '0;
      bus.cores_en_o   <= 1'b0;
      bus.boot_done_o  <= 1'b0;
      bus.boot_err_o   <= 1'b0;
      bus.boot_sum_o   <= '0;
    end else begin
      bus.spi_start_o <= 1'b0;
      // Timeout is only taken when no done arrives this cycle, so done wins a tie
      if (is_wait && !bus.spi_done_i) begin
        if (wd_expired) begin
          state           <= ERROR;
          bus.flash_csb_o <= 1'b1;
          bus.boot_err_o  <= 1'b1;
          bus.cores_en_o  <= 1'b0;
        end else begin
          wdog <= wdog + WW'(1);
        end
      end else begin
        case (state)
          IDLE: begin
            bus.flash_csb_o <= 1'b0;
            state           <= CMD_SEND;
          end
          CMD_SEND: if (spi_go) begin
            bus.spi_start_o <= 1'b1;
            bus.spi_out_o   <= CMD_BYTE;
            wdog            <= '0;
            state           <= CMD_WAIT;
          end
          CMD_WAIT: begin
            addr_idx <= '0;
            state    <= ADDR_SEND;
          end
          ADDR_SEND: if (spi_go) begin
            bus.spi_start_o <= 1'b1;
            bus.spi_out_o   <= addr_byte;
            wdog            <= '0;
            state           <= ADDR_WAIT;
          end
          ADDR_WAIT: begin
            if (addr_idx == 2'd2) begin
              state <= FAST_READ ? DUMMY_SEND : DATA_SEND;
            end else begin
              addr_idx <= addr_idx + 2'd1;
              state    <= ADDR_SEND;
            end
          end
          DUMMY_SEND: if (spi_go) begin
            bus.spi_start_o <= 1'b1;
            bus.spi_out_o   <= '0;
            wdog            <= '0;
            state           <= DUMMY_WAIT;
          end
          DUMMY_WAIT: state <= DATA_SEND;
          DATA_SEND: if (spi_go) begin
            bus.spi_start_o <= 1'b1;
            bus.spi_out_o   <= '0;
            wdog            <= '0;
            state           <= DATA_WAIT;
          end
          DATA_WAIT: begin
            byte_cntr      <= byte_cntr + CW'(1);
            bus.boot_sum_o <= bus.boot_sum_o + {24'h0, bus.spi_in_i};
            if (pack_full || (byte_cntr == LAST_BYTE)) begin
              bus.sram_wr_en_o <= 1'b1;
              bus.sram_addr_o  <= addr_reg;
              state            <= SRAM_WRITE;
            end else begin
              state <= DATA_SEND;
            end
          end
          SRAM_WRITE: if (bus.sram_ready_i) begin
            bus.sram_wr_en_o <= 1'b0;
            addr_reg         <= addr_reg + ADDR_STEP;
            if (byte_cntr == ALL_BYTES) begin
              bus.flash_csb_o <= 1'b1;
              state           <= CS_END;
            end else begin
              state <= DATA_SEND;
            end
          end
          CS_END: begin
            bus.boot_done_o <= 1'b1;
            bus.cores_en_o  <= 1'b1;
            state           <= DONE;
          end
          DONE, ERROR: if (restart) begin
            bus.boot_done_o <= 1'b0;
            bus.boot_err_o  <= 1'b0;
            bus.cores_en_o  <= 1'b0;
            bus.boot_sum_o  <= '0;
            byte_cntr       <= '0;
            wdog            <= '0;
            addr_idx        <= '0;
            addr_reg        <= SRAM_BASE_ADDR;
            state           <= IDLE;
          end
          default: begin
            bus.flash_csb_o <= 1'b1;
            state           <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Directed bench: three loader configurations against a small SPI flash / SRAM model.
module tb_flash_boot_loader;

  logic clk;
  logic rst_n;

  flash_boot_loader_if #(.WORD_BYTES(4)) bus [3] ();

  // 0: defaults, 1: FAST_READ at 0x012345, 2: 6-byte big-endian image
  flash_boot_loader u_a (.clk_i(clk), .reset_ni(rst_n), .bus(bus[0]));

  flash_boot_loader #(
    .BOOT_SIZE       (8),
    .FLASH_BASE_ADDR (24'h012345),
    .FAST_READ       (1'b1)
  ) u_b (.clk_i(clk), .reset_ni(rst_n), .bus(bus[1]));

  flash_boot_loader #(
    .BOOT_SIZE  (6),
    .BIG_ENDIAN (1'b1)
  ) u_c (.clk_i(clk), .reset_ni(rst_n), .bus(bus[2]));

  logic        st [3], cs [3], wr [3], bdone [3], err [3], en [3];
  logic [7:0]  so [3];
  logic [31:0] ad [3], dt [3], sum [3];
  logic [7:0]  rx [3];
  logic        sdone [3], eb [3], fb [3], rdy [3], req [3], hold_addr [3];
  int          lat [3], cnt [3], cur [3];

  logic [7:0]  mosi_log [3][256];
  logic [31:0] addr_log [3][128];
  logic [31:0] data_log [3][128];
  int          mosi_n [3] = '{0, 0, 0};
  int          wr_n   [3] = '{0, 0, 0};

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_conn
    assign st[g]    = bus[g].spi_start_o;
    assign so[g]    = bus[g].spi_out_o;
    assign cs[g]    = bus[g].flash_csb_o;
    assign wr[g]    = bus[g].sram_wr_en_o;
    assign ad[g]    = bus[g].sram_addr_o;
    assign dt[g]    = bus[g].sram_data_o;
    assign bdone[g] = bus[g].boot_done_o;
    assign err[g]   = bus[g].boot_err_o;
    assign en[g]    = bus[g].cores_en_o;
    assign sum[g]   = bus[g].boot_sum_o;
    assign bus[g].spi_in_i     = rx[g];
    assign bus[g].spi_done_i   = sdone[g];
    assign bus[g].spi_busy_i   = eb[g] | fb[g];
    assign bus[g].sram_ready_i = rdy[g];
    assign bus[g].boot_req_i   = req[g];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] flash_byte(input int g, input int idx);
    int hl;
    hl = (g == 1) ? 5 : 4;
    if (idx < hl) return 8'h00;
    case (g)
      0:       return 8'(idx - hl);
      1:       return 8'(8'h10 + idx - hl);
      default: return 8'(8'hAA + 8'h11 * (idx - hl));
    endcase
  endfunction

  // SPI engine: two-cycle transfers; flash content indexed by position in the chip-select frame
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      sdone[g] <= 1'b0;
      if (!rst_n) begin
        lat[g] <= 0;
        cnt[g] <= 0;
        eb[g]  <= 1'b0;
        rx[g]  <= 8'h00;
      end else begin
        if (cs[g]) cnt[g] <= 0;
        if (st[g]) begin
          if (mosi_n[g] < 256) mosi_log[g][mosi_n[g]] <= so[g];
          mosi_n[g] <= mosi_n[g] + 1;
          cur[g]    <= cnt[g];
          cnt[g]    <= cnt[g] + 1;
          lat[g]    <= 2;
          eb[g]     <= 1'b1;
          rx[g]     <= flash_byte(g, cnt[g]);
        end else if (lat[g] != 0) begin
          lat[g] <= lat[g] - 1;
          if (lat[g] == 1) begin
            eb[g]    <= 1'b0;
            sdone[g] <= !(hold_addr[g] && cur[g] == 1);
          end
        end
        if (wr[g] && rdy[g]) begin
          if (wr_n[g] < 128) begin
            addr_log[g][wr_n[g]] <= ad[g];
            data_log[g][wr_n[g]] <= dt[g];
          end
          wr_n[g] <= wr_n[g] + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input int g, input string tag);
    int n;
    n = 0;
    while (!bdone[g] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, bdone[g], 1'b1);
  endtask

  task automatic pulse_req(input int g);
    @(negedge clk);
    req[g] = 1'b1;
    @(negedge clk);
    req[g] = 1'b0;
    check("req_clears_done", bdone[g], 1'b0);
    check("req_clears_err", err[g], 1'b0);
    check("req_clears_en", en[g], 1'b0);
  endtask

  initial begin
    int w0, n, k;
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      fb[g] = 1'b0; rdy[g] = 1'b1; req[g] = 1'b0; hold_addr[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g += 2) begin
      check("rst_csb", cs[g], 1'b1);
      check("rst_start", st[g], 1'b0);
      check("rst_out", so[g], 8'h00);
      check("rst_wr", wr[g], 1'b0);
      check("rst_addr", ad[g], 32'h0);
      check("rst_data", dt[g], 32'h0);
      check("rst_en", en[g], 1'b0);
      check("rst_done", bdone[g], 1'b0);
      check("rst_err", err[g], 1'b0);
      check("rst_sum", sum[g], 32'h0);
    end
    rst_n = 1'b1;

    // First boots run on their own after reset release
    wait_done(2, "c_done");
    check("c_writes", wr_n[2], 2);
    check("c_w0_addr", addr_log[2][0], 32'h0);
    check("c_w0_data", data_log[2][0], 32'hAABBCCDD);
    check("c_w1_addr", addr_log[2][1], 32'h4);
    check("c_w1_data", data_log[2][1], 32'hEEFF0000);
    check("c_sum", sum[2], 32'h4FB);

    wait_done(1, "b_done");
    check("b_mosi_cmd", mosi_log[1][0], 8'h0B);
    check("b_mosi_a2", mosi_log[1][1], 8'h01);
    check("b_mosi_a1", mosi_log[1][2], 8'h23);
    check("b_mosi_a0", mosi_log[1][3], 8'h45);
    check("b_mosi_dummy", mosi_log[1][4], 8'h00);
    check("b_mosi_count", mosi_n[1], 13);
    check("b_w0_data", data_log[1][0], 32'h13121110);
    check("b_w1_data", data_log[1][1], 32'h17161514);
    check("b_w1_addr", addr_log[1][1], 32'h4);
    check("b_sum", sum[1], 32'h9C);

    wait_done(0, "a_done");
    check("a_mosi_cmd", mosi_log[0][0], 8'h03);
    check("a_mosi_a2", mosi_log[0][1], 8'h00);
    check("a_mosi_a1", mosi_log[0][2], 8'h00);
    check("a_mosi_a0", mosi_log[0][3], 8'h00);
    check("a_mosi_data", mosi_log[0][4], 8'h00);
    check("a_mosi_count", mosi_n[0], 36);
    check("a_writes", wr_n[0], 8);
    for (int i = 0; i < 8; i++) begin
      check("a_addr", addr_log[0][i], 32'(4 * i));
      check("a_data", data_log[0][i],
            {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)});
    end
    check("a_sum", sum[0], 32'h1F0);
    check("a_en", en[0], 1'b1);
    check("a_csb_done", cs[0], 1'b1);
    check("a_err", err[0], 1'b0);

    // SRAM back-pressure on the second write
    w0 = wr_n[0];
    pulse_req(0);
    n = 0;
    while (wr_n[0] != w0 + 1 && n < 500) begin @(negedge clk); n++; end
    check("bp_first_write", wr_n[0] - w0, 1);
    rdy[0] = 1'b0;
    n = 0;
    while (!wr[0] && n < 500) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      check("bp_wr_held", wr[0], 1'b1);
      check("bp_addr_held", ad[0], 32'h4);
      check("bp_data_held", dt[0], 32'h07060504);
      check("bp_no_start", st[0], 1'b0);
      @(negedge clk);
    end
    rdy[0] = 1'b1;
    wait_done(0, "bp_done");
    check("bp_writes", wr_n[0] - w0, 8);
    check("bp_w1_data", data_log[0][w0 + 1], 32'h07060504);
    check("bp_sum", sum[0], 32'h1F0);

    // Watchdog: first address byte never completes
    w0 = wr_n[0];
    pulse_req(0);
    hold_addr[0] = 1'b1;
    n = 0;
    while (!(st[0] && cnt[0] == 1) && n < 500) begin @(negedge clk); n++; end
    check("wd_addr_start", st[0], 1'b1);
    k = 0;
    while (!err[0] && k < 2000) begin @(negedge clk); k++; end
    check("wd_cycles", k, 1024);
    check("wd_err", err[0], 1'b1);
    check("wd_csb", cs[0], 1'b1);
    check("wd_en", en[0], 1'b0);
    check("wd_done", bdone[0], 1'b0);
    check("wd_no_writes", wr_n[0] - w0, 0);
    hold_addr[0] = 1'b0;
    pulse_req(0);
    wait_done(0, "wd_reboot_done");
    check("wd_reboot_err", err[0], 1'b0);
    check("wd_reboot_sum", sum[0], 32'h1F0);

    // Busy engine during DATA_SEND holds off the start pulse
    pulse_req(0);
    n = 0;
    while (!(sdone[0] && cnt[0] == 6) && n < 500) begin @(negedge clk); n++; end
    check("busy_sync", sdone[0], 1'b1);
    fb[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_no_start", st[0], 1'b0);
    end
    fb[0] = 1'b0;
    k = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (st[0]) k++;
    end
    check("busy_one_pulse", k, 1);
    wait_done(0, "busy_done");
    check("busy_sum", sum[0], 32'h1F0);

    // Asynchronous reset in the middle of the data phase
    pulse_req(0);
    n = 0;
    while (cnt[0] < 10 && n < 500) begin @(negedge clk); n++; end
    check("mid_csb_low", cs[0], 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_csb", cs[0], 1'b1);
    check("mid_rst_sum", sum[0], 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_done(0, "rerun_done");
    check("rerun_sum", sum[0], 32'h1F0);
    check("rerun_err", err[0], 1'b0);
    check("rerun_en", en[0], 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/flash_boot_loader.md
Name: flash_boot_loader

Overview:
- Parametrised successor to the fixed 32-byte boot sequencer.
- Copies a configurable image from SPI NOR flash into on-chip SRAM through the shared byte-wide SPI engine, then enables the cores.
- Adds the following over the fixed sequencer:
  - programmable flash start address;
  - optional FAST_READ (0x0B plus dummy byte);
  - configurable SRAM word width and endianness;
  - SRAM ready back-pressure;
  - partial-last-word handling;
  - byte checksum;
  - SPI watchdog with error state;
  - re-boot on request.

Parameters:
- BOOT_SIZE, 32, image length in bytes; must be >= 1.
- FLASH_BASE_ADDR, 24'h000000, flash start address; sent MSB byte first.
- SRAM_BASE_ADDR, 32'h0000_0000, first SRAM word address.
- WORD_BYTES, 4, bytes per SRAM word; legal values 1/2/4/8; SRAM address step = WORD_BYTES.
- FAST_READ, 0, 0 = command 0x03; 1 = command 0x0B followed by one 0x00 dummy byte.
- BIG_ENDIAN, 0, 0 = first byte lands in bits [7:0]; 1 = first byte lands in the top byte.
- TIMEOUT_CYCLES, 1024, maximum cycles spent in any WAIT state before error.

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  asynchronous active-low reset
- boot_req_i  in  1  start/restart pulse, honoured in IDLE, DONE, ERROR
- spi_start_o  out  1  one-cycle pulse that launches one SPI byte transfer
- spi_out_o  out  8  byte to shift out
- spi_in_i  in  8  received byte, valid with spi_done_i
- spi_done_i  in  1  one-cycle transfer-complete pulse
- spi_busy_i  in  1  SPI engine busy
- flash_csb_o  out  1  flash chip select, active low
- sram_wr_en_o  out  1  SRAM write request
- sram_ready_i  in  1  SRAM accepts the write when sram_wr_en_o && sram_ready_i
- sram_addr_o  out  32  SRAM byte address
- sram_data_o  out  8*WORD_BYTES  SRAM write data
- cores_en_o  out  1  core enable
- boot_done_o  out  1  image loaded
- boot_err_o  out  1  SPI timeout occurred
- boot_sum_o  out  32  mod-2^32 sum of all image bytes; stable once boot_done_o=1

Behaviour:
- Reset values (asynchronous, while reset_ni=0):
  - state IDLE; flash_csb_o=1.
  - All other outputs 0: spi_start_o, spi_out_o, sram_wr_en_o, sram_addr_o=0, sram_data_o, cores_en_o, boot_done_o, boot_err_o, boot_sum_o.
  - Internal counters 0; internal SRAM address register = SRAM_BASE_ADDR.
- Start and ordering:
  - First boot begins automatically one cycle after reset release, with an implicit boot_req.
  - Later boots start only via boot_req_i.
  - Order: IDLE -> CMD -> ADDR x3 -> [DUMMY if FAST_READ] -> DATA/WRITE loop -> CS_END -> DONE.
- SEND/WAIT pairs: every byte phase has a SEND state and a WAIT state.
  - SEND:
    - flash_csb_o=0.
    - spi_start_o=1 for exactly one cycle, only when spi_busy_i=0; while spi_busy_i=1 it stays in SEND with spi_start_o=0.
    - Moves to WAIT the cycle after the start pulse.
  - WAIT: holds flash_csb_o=0 until spi_done_i.
- Byte values by phase:
  - CMD: 0x03 or 0x0B.
  - ADDR: FLASH_BASE_ADDR[23:16], [15:8], then [7:0].
  - DUMMY and DATA: 0x00.
- DATA_WAIT on spi_done_i:
  - Byte placed at lane byte_in_word, mirrored when BIG_ENDIAN=1.
  - byte_in_word++ and byte_cntr++.
  - boot_sum += zero-extended byte.
  - Goes to SRAM_WRITE when the word is full or byte_cntr reaches BOOT_SIZE; otherwise back to DATA_SEND.
- Partial last word: when BOOT_SIZE % WORD_BYTES != 0, the final word is written with unfilled lanes = 0.
- Word buffer clearing: the buffer is cleared after every accepted write, so stale bytes never leak.
- SRAM_WRITE:
  - sram_wr_en_o=1; address and data held stable until sram_ready_i=1.
  - On acceptance: sram_addr += WORD_BYTES; byte_in_word=0.
  - Next state: CS_END if all bytes have been read, else DATA_SEND.
  - flash_csb_o stays 0 throughout, so the flash read stream continues.
- CS_END: one cycle with flash_csb_o=1, then DONE.
- DONE:
  - flash_csb_o=1, boot_done_o=1, cores_en_o=1.
  - Holds until boot_req_i.
- Watchdog:
  - Counter resets on entry to each WAIT state.
  - Reaching TIMEOUT_CYCLES in a WAIT state -> ERROR: flash_csb_o=1, boot_err_o=1, cores_en_o=0, no SRAM writes.
- Restart:
  - boot_req_i in DONE or ERROR -> IDLE next cycle.
  - Clears boot_done_o, boot_err_o, cores_en_o, counters, sum; reloads SRAM_BASE_ADDR.
  - boot_req_i in any other state is ignored.
- Simultaneous events:
  - spi_done_i in the same cycle the watchdog expires: done wins and the phase advances.
  - spi_done_i outside WAIT states is ignored.
- Reset mid-boot: immediate abort; flash_csb_o=1 asynchronously.
- Counters:
  - byte_cntr width $clog2(BOOT_SIZE+1).
  - Watchdog counter width $clog2(TIMEOUT_CYCLES+1).
  - No wrap occurs within a boot.

Decomposition:
- Package boot_pkg holds:
  - the boot_state_t enum: IDLE, CMD_SEND, CMD_WAIT, ADDR_SEND, ADDR_WAIT, DUMMY_SEND, DUMMY_WAIT, DATA_SEND, DATA_WAIT, SRAM_WRITE, CS_END, DONE, ERROR;
  - localparams FLASH_CMD_READ=8'h03 and FLASH_CMD_FAST_READ=8'h0B.
- One sub-module, boot_word_packer (parameters WORD_BYTES and BIG_ENDIAN), owns:
  - lane select and byte insert;
  - the full flag;
  - clear on write acceptance.

Test Plan:
- Defaults; flash bytes = index (0x00..0x1F); sram_ready_i=1 -> 8 writes to 0x00..0x1C; first data 0x03020100, last data 0x1F1E1D1C; boot_sum_o=0x1F0; cores_en_o=1; MOSI = 03 00 00 00 then data.
- FAST_READ=1, FLASH_BASE_ADDR=24'h012345 -> MOSI = 0B 01 23 45 00; first data byte read after the dummy byte.
- BOOT_SIZE=6, WORD_BYTES=4, BIG_ENDIAN=1, bytes AA BB CC DD EE FF -> writes 0xAABBCCDD @0x0 and 0xEEFF0000 @0x4; then DONE.
- sram_ready_i held low 5 cycles on the 2nd write -> sram_wr_en_o, addr 0x4 and data remain stable; no SPI start pulses; resumes after ready.
- spi_done_i withheld in ADDR_WAIT for TIMEOUT_CYCLES -> ERROR, boot_err_o=1, flash_csb_o=1; then a boot_req_i pulse -> full reboot completes, boot_err_o=0.
- spi_busy_i=1 for 3 cycles during DATA_SEND -> no spi_start_o until busy drops; exactly one pulse follows. reset_ni asserted mid-DATA -> flash_csb_o=1 immediately; rerun succeeds.
